// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: result-select encodings and register-file index width.
package pipeline_pkg;

   localparam int REG_IDX_W = 5;

   typedef enum logic [2:0] {
      RES_ALU      = 3'b000,
      RES_PCTARGET = 3'b001,
      RES_PCPLUS4  = 3'b010,
      RES_IMM      = 3'b011,
      RES_MEM      = 3'b100
   } result_src_e;

endpackage

// File: rtl/retire_counters.sv
// Free-running cycle counter and retired-instruction counter; both wrap.
module retire_counters #(
   parameter int CNT_WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 retire,
   output logic [CNT_WIDTH-1:0] cycle_cnt,
   output logic [CNT_WIDTH-1:0] instret_cnt
);

   // Count every non-reset cycle and every retire event
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 1'b1;
         if (retire)
            instret_cnt <= instret_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: M/W pipeline register, result select, RF write port drive,
// one-entry retired-write history for late bypass.
// Optional cycle/instret counters are built when WB_RETIRE_COUNTERS_EN is defined;
// otherwise CycleCntW and InstRetCntW read 0.
module writeback_stage
   import pipeline_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int CNT_WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     ALUResultM,
   input  logic [WIDTH-1:0]     ReducedDataM,
   input  logic [WIDTH-1:0]     PCTargetM,
   input  logic [WIDTH-1:0]     PCPlus4M,
   input  logic [WIDTH-1:0]     ImmExtM,
   input  logic [REG_IDX_W-1:0] RdM,
   input  logic [2:0]           ResultSrcM,
   input  logic                 RegWriteM,
   input  logic                 ValidM,
   input  logic                 StallW,
   input  logic                 FlushW,
   output logic [WIDTH-1:0]     ResultW,
   output logic [REG_IDX_W-1:0] RdW,
   output logic                 RegWriteW,
   output logic                 ValidW,
   output logic [WIDTH-1:0]     HistDataW,
   output logic [REG_IDX_W-1:0] HistRdW,
   output logic                 HistValidW,
   output logic [CNT_WIDTH-1:0] CycleCntW,
   output logic [CNT_WIDTH-1:0] InstRetCntW
);

   logic [WIDTH-1:0]     alu_result_p1;
   logic [WIDTH-1:0]     reduced_data_p1;
   logic [WIDTH-1:0]     pc_target_p1;
   logic [WIDTH-1:0]     pc_plus4_p1;
   logic [WIDTH-1:0]     imm_ext_p1;
   logic [REG_IDX_W-1:0] rd_p1;
   logic [2:0]           result_src_p1;
   logic                 reg_write_p1;
   logic                 vld_p1;

   logic                 load_en;
   logic                 reg_write_d;
   logic                 vld_d;
   logic                 retire;

   // Flush overrides stall: it opens the register and zeroes the control bits on D
   always_comb begin
      load_en     = ~StallW | FlushW;
      reg_write_d = RegWriteM & ~FlushW;
      vld_d       = ValidM & ~FlushW;
   end

   // ---- M -> W stage boundary ----
   // W register; the data fields follow M even on a flush, only control is killed
   always_ff @(posedge clk) begin
      if (reset) begin
         alu_result_p1   <= '0;
         reduced_data_p1 <= '0;
         pc_target_p1    <= '0;
         pc_plus4_p1     <= '0;
         imm_ext_p1      <= '0;
         rd_p1           <= '0;
         result_src_p1   <= '0;
         reg_write_p1    <= 1'b0;
         vld_p1          <= 1'b0;
      end else if (load_en) begin
         alu_result_p1   <= ALUResultM;
         reduced_data_p1 <= ReducedDataM;
         pc_target_p1    <= PCTargetM;
         pc_plus4_p1     <= PCPlus4M;
         imm_ext_p1      <= ImmExtM;
         rd_p1           <= RdM;
         result_src_p1   <= ResultSrcM;
         reg_write_p1    <= reg_write_d;
         vld_p1          <= vld_d;
      end
   end

   // Result select: bit 2 picks load data, otherwise the low two bits choose
   always_comb begin
      ResultW = imm_ext_p1;
      if (result_src_p1[2]) begin
         ResultW = reduced_data_p1;
      end else begin
         case (result_src_e'({1'b0, result_src_p1[1:0]}))
            RES_ALU:      ResultW = alu_result_p1;
            RES_PCTARGET: ResultW = pc_target_p1;
            RES_PCPLUS4:  ResultW = pc_plus4_p1;
            default:      ResultW = imm_ext_p1;
         endcase
      end
   end

   // RF write port drive; writes to x0 and bubbles are suppressed here
   always_comb begin
      RdW       = rd_p1;
      ValidW    = vld_p1;
      RegWriteW = reg_write_p1 & vld_p1 & (rd_p1 != '0);
      retire    = vld_p1 & ~StallW;
   end

   // History captures the last write that actually left W; only reset clears it
   always_ff @(posedge clk) begin
      if (reset) begin
         HistDataW  <= '0;
         HistRdW    <= '0;
         HistValidW <= 1'b0;
      end else if (retire && RegWriteW) begin
         HistDataW  <= ResultW;
         HistRdW    <= RdW;
         HistValidW <= 1'b1;
      end
   end

`ifdef WB_RETIRE_COUNTERS_EN
   retire_counters #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_retire_counters (
      .clk         (clk),
      .reset       (reset),
      .retire      (retire),
      .cycle_cnt   (CycleCntW),
      .instret_cnt (InstRetCntW)
   );
`else
   assign CycleCntW   = '0;
   assign InstRetCntW = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed testbench for writeback_stage (works with or without WB_RETIRE_COUNTERS_EN).
module tb_writeback_stage;

   logic        clk;
   logic        reset;
   logic [31:0] ALUResultM, ReducedDataM, PCTargetM, PCPlus4M, ImmExtM;
   logic [4:0]  RdM;
   logic [2:0]  ResultSrcM;
   logic        RegWriteM, ValidM, StallW, FlushW;
   logic [31:0] ResultW, HistDataW;
   logic [4:0]  RdW, HistRdW;
   logic        RegWriteW, ValidW, HistValidW;
   logic [63:0] CycleCntW, InstRetCntW;

   int tests = 0;
   int fails = 0;

   // Bench-side control model for the counters
   logic        m_valid;
   logic [63:0] m_cyc, m_ret;

   writeback_stage #(.WIDTH(32), .CNT_WIDTH(64)) dut (
      .clk(clk), .reset(reset),
      .ALUResultM(ALUResultM), .ReducedDataM(ReducedDataM), .PCTargetM(PCTargetM),
      .PCPlus4M(PCPlus4M), .ImmExtM(ImmExtM), .RdM(RdM), .ResultSrcM(ResultSrcM),
      .RegWriteM(RegWriteM), .ValidM(ValidM), .StallW(StallW), .FlushW(FlushW),
      .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW), .ValidW(ValidW),
      .HistDataW(HistDataW), .HistRdW(HistRdW), .HistValidW(HistValidW),
      .CycleCntW(CycleCntW), .InstRetCntW(InstRetCntW)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock edge; model follows the driven controls, outputs sampled 1 unit later
   task automatic step();
      @(posedge clk);
      if (reset) begin
         m_valid = 1'b0; m_cyc = '0; m_ret = '0;
      end else begin
         m_cyc = m_cyc + 1;
         if (m_valid && !StallW) m_ret = m_ret + 1;
         if (FlushW) m_valid = 1'b0;
         else if (!StallW) m_valid = ValidM;
      end
      #1;
   endtask

   task automatic chk_cnt(input string tag);
`ifdef WB_RETIRE_COUNTERS_EN
      chk({tag, "_cycle"}, CycleCntW, m_cyc);
      chk({tag, "_instret"}, InstRetCntW, m_ret);
`else
      chk({tag, "_cycle"}, CycleCntW, 64'd0);
      chk({tag, "_instret"}, InstRetCntW, 64'd0);
`endif
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_result"}, {32'd0, ResultW}, 64'd0);
      chk({tag, "_rd"}, {59'd0, RdW}, 64'd0);
      chk({tag, "_regwrite"}, {63'd0, RegWriteW}, 64'd0);
      chk({tag, "_valid"}, {63'd0, ValidW}, 64'd0);
      chk({tag, "_histdata"}, {32'd0, HistDataW}, 64'd0);
      chk({tag, "_histrd"}, {59'd0, HistRdW}, 64'd0);
      chk({tag, "_histvalid"}, {63'd0, HistValidW}, 64'd0);
      chk({tag, "_cycle"}, CycleCntW, 64'd0);
      chk({tag, "_instret"}, InstRetCntW, 64'd0);
   endtask

   logic [2:0]  srcs [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b111};
   logic [31:0] exps [6] = '{32'h11, 32'h33, 32'h44, 32'h55, 32'h22, 32'h22};

   initial begin
      m_valid = 1'b0; m_cyc = '0; m_ret = '0;
      reset = 1'b1;
      ALUResultM = '0; ReducedDataM = '0; PCTargetM = '0; PCPlus4M = '0; ImmExtM = '0;
      RdM = '0; ResultSrcM = '0; RegWriteM = 1'b0; ValidM = 1'b0;
      StallW = 1'b0; FlushW = 1'b0;
      step(); step();
      chk_zero("reset");
      reset = 1'b0;

      // Result mux sweep; each step also retires the previous write into history
      ALUResultM = 32'h11; ReducedDataM = 32'h22; PCTargetM = 32'h33;
      PCPlus4M = 32'h44; ImmExtM = 32'h55;
      RdM = 5'd5; RegWriteM = 1'b1; ValidM = 1'b1;
      for (int i = 0; i < 6; i++) begin
         ResultSrcM = srcs[i];
         step();
         chk($sformatf("mux_src%0d", i), {32'd0, ResultW}, {32'd0, exps[i]});
         chk($sformatf("mux_regwrite%0d", i), {63'd0, RegWriteW}, 64'd1);
         if (i > 0) begin
            chk($sformatf("mux_hist%0d", i), {32'd0, HistDataW}, {32'd0, exps[i-1]});
            chk($sformatf("mux_histvalid%0d", i), {63'd0, HistValidW}, 64'd1);
         end
      end
      chk_cnt("mux");

      // Write to x0: no RF write, history keeps the last real write
      RdM = 5'd0; ResultSrcM = 3'b000;
      step();
      chk("x0_regwrite", {63'd0, RegWriteW}, 64'd0);
      chk("x0_valid", {63'd0, ValidW}, 64'd1);
      chk("x0_hist_before", {32'd0, HistDataW}, 64'h22);
      ValidM = 1'b0;
      step();
      chk("x0_hist_after", {32'd0, HistDataW}, 64'h22);
      chk("x0_histrd_after", {59'd0, HistRdW}, 64'd5);
      chk_cnt("x0");

      // Stall for three cycles with a valid instruction held in W
      ValidM = 1'b1; RdM = 5'd7; ALUResultM = 32'hAA;
      step();
      chk("stall_load_result", {32'd0, ResultW}, 64'hAA);
      StallW = 1'b1; ALUResultM = 32'hBB; RdM = 5'd8;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("stall_result%0d", i), {32'd0, ResultW}, 64'hAA);
         chk($sformatf("stall_rd%0d", i), {59'd0, RdW}, 64'd7);
         chk($sformatf("stall_valid%0d", i), {63'd0, ValidW}, 64'd1);
         chk($sformatf("stall_hist%0d", i), {32'd0, HistDataW}, 64'h22);
         chk_cnt($sformatf("stall%0d", i));
      end
      StallW = 1'b0; ValidM = 1'b0;
      step();
      chk("unstall_hist", {32'd0, HistDataW}, 64'hAA);
      chk("unstall_histrd", {59'd0, HistRdW}, 64'd7);
      chk("unstall_valid", {63'd0, ValidW}, 64'd0);
      chk_cnt("unstall");
      step();
      chk("bubble_hist", {32'd0, HistDataW}, 64'hAA);
      chk_cnt("bubble");

      // Stall and flush together: flush wins, nothing retires
      ValidM = 1'b1; RdM = 5'd9; ALUResultM = 32'hCC;
      step();
      chk("sf_load_valid", {63'd0, ValidW}, 64'd1);
      StallW = 1'b1; FlushW = 1'b1;
      step();
      chk("sf_valid", {63'd0, ValidW}, 64'd0);
      chk("sf_regwrite", {63'd0, RegWriteW}, 64'd0);
      chk("sf_hist", {32'd0, HistDataW}, 64'hAA);
      chk("sf_histrd", {59'd0, HistRdW}, 64'd7);
      chk_cnt("sf");
      StallW = 1'b0; FlushW = 1'b0; ValidM = 1'b0;
      step();
      chk("sf_after_hist", {32'd0, HistDataW}, 64'hAA);
      chk_cnt("sf_after");

`ifdef WB_RETIRE_COUNTERS_EN
      // Counters preloaded to all ones wrap to zero on the next event
      ValidM = 1'b1; RdM = 5'd4;
      step();
      ValidM = 1'b0;
      force dut.u_retire_counters.cycle_cnt = '1;
      force dut.u_retire_counters.instret_cnt = '1;
      #1;
      release dut.u_retire_counters.cycle_cnt;
      release dut.u_retire_counters.instret_cnt;
      m_cyc = '1; m_ret = '1;
      step();
      chk("wrap_cycle", CycleCntW, 64'd0);
      chk("wrap_instret", InstRetCntW, 64'd0);
`endif

      // Reset mid-stream with a valid instruction in W
      ValidM = 1'b1; RdM = 5'd3; ALUResultM = 32'h77; RegWriteM = 1'b1; ResultSrcM = 3'b000;
      step();
      chk("mid_valid", {63'd0, ValidW}, 64'd1);
      chk("mid_regwrite", {63'd0, RegWriteW}, 64'd1);
      reset = 1'b1;
      step();
      chk_zero("midreset");
      reset = 1'b0; ValidM = 1'b0;
      step();
      chk_cnt("post_reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Hard bound so the run always ends on its own
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
